// File: rtl/magic_button_ctrl_pkg.sv
// Shared types and helpers for the magic-button front end.
package magic_button_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    typedef enum logic [1:0] {
        BTN_IDLE     = ST_IDLE,
        BTN_PRESSED  = ST_PRESSED,
        BTN_WAIT_REL = ST_WAIT_REL
    } btnstate_t;

    // Bits needed for a counter that must hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/magic_button_ctrl_debounce.sv
// 2-FF synchroniser plus debounce for an active-low front-panel key.
module debounce
    import magic_button_ctrl_pkg::*;
#(
    parameter int unsigned CYCLES = 560_000
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic btn_n_raw_i,
    output logic btn_stable_o
);

    localparam int unsigned CW = cnt_width(CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any agreeing cycle restarts the count, so a glitch never accumulates.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_stable_o = stable_q;

endmodule

// File: rtl/magic_button_ctrl.sv
// Magic button front end: short press / hotkey -> menu request,
// long press / reboot write -> timed system reset.
module magic_button_ctrl
    import magic_button_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 560_000,
    parameter int unsigned LONG_CYCLES       = 56_000_000,
    parameter int unsigned RESET_HOLD_CYCLES = 2_800
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic btn_n_raw,
    input  logic ps2_magic_key,
    input  logic magic_mode,
    input  logic magic_reboot,
    output logic magic_button,
    output logic sys_rst_n
);

    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam int unsigned RW = cnt_width(RESET_HOLD_CYCLES);

    logic          btn_stable;
    logic          pressed;
    btnstate_t     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          short_evt;
    logic          long_evt;

    logic          por_q;
    logic          reboot_q;
    logic          trig;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          magic_button_q, magic_button_d;

    debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .btn_n_raw_i (btn_n_raw),
        .btn_stable_o(btn_stable)
    );

    assign pressed = ~btn_stable;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        unique case (state_q)
            BTN_IDLE: begin
                if (pressed) begin
                    state_d = BTN_PRESSED;
                    hold_d  = '0;
                end
            end
            BTN_PRESSED: begin
                if (pressed) begin
                    if (hold_q == HW'(LONG_CYCLES - 1)) begin
                        long_evt = 1'b1;
                        state_d  = BTN_WAIT_REL;
                    end else if (hold_q != '1) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    short_evt = (hold_q < HW'(LONG_CYCLES - 1));
                    state_d   = BTN_IDLE;
                end
            end
            BTN_WAIT_REL: begin
                if (!pressed) begin
                    state_d = BTN_IDLE;
                end
            end
            default: state_d = BTN_IDLE;
        endcase
    end

    // por_q fires one trigger on the first clock after rst_n releases.
    assign trig = por_q | long_evt | (magic_reboot & ~reboot_q);

    always_comb begin
        rst_cnt_d = '0;
        if (trig) begin
            rst_cnt_d = RW'(RESET_HOLD_CYCLES);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RW'(1);
        end
        sys_rst_n_d    = (rst_cnt_d == '0);
        magic_button_d = (magic_button_q | short_evt | ps2_magic_key)
                         & ~magic_mode & sys_rst_n_q;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BTN_IDLE;
            hold_q         <= '0;
            por_q          <= 1'b1;
            reboot_q       <= 1'b0;
            rst_cnt_q      <= '0;
            sys_rst_n_q    <= 1'b0;
            magic_button_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            por_q          <= 1'b0;
            reboot_q       <= magic_reboot;
            rst_cnt_q      <= rst_cnt_d;
            sys_rst_n_q    <= sys_rst_n_d;
            magic_button_q <= magic_button_d;
        end
    end

    assign magic_button = magic_button_q;
    assign sys_rst_n    = sys_rst_n_q;

endmodule

// File: tb/tb_magic_button_ctrl.sv
// Self-checking bench for magic_button_ctrl with a cycle-level behavioural model.
module tb_magic_button_ctrl;

    localparam int DEB  = 8;
    localparam int LONG = 100;
    localparam int HOLD = 16;

    logic clk28 = 1'b0;
    logic rst_n;
    logic btn_n_raw;
    logic ps2_magic_key;
    logic magic_mode;
    logic magic_reboot;
    logic magic_button;
    logic sys_rst_n;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    always #5 clk28 = ~clk28;

    magic_button_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_CYCLES      (LONG),
        .RESET_HOLD_CYCLES(HOLD)
    ) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .btn_n_raw    (btn_n_raw),
        .ps2_magic_key(ps2_magic_key),
        .magic_mode   (magic_mode),
        .magic_reboot (magic_reboot),
        .magic_button (magic_button),
        .sys_rst_n    (sys_rst_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin pipeline, mismatch run length, press age in cycles, trigger time.
    bit m_s1, m_s2, m_stable, m_req, m_reboot_prev, m_por;
    int m_run, m_mode, m_age, m_cyc, m_last_trig;
    bit exp_sys;

    assign exp_sys = !m_por && ((m_cyc - m_last_trig) >= HOLD);

    always @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b1; m_s2 <= 1'b1; m_stable <= 1'b1; m_req <= 1'b0;
            m_reboot_prev <= 1'b0; m_por <= 1'b1;
            m_run <= 0; m_mode <= 0; m_age <= 0; m_cyc <= 0; m_last_trig <= 0;
        end else begin : step
            int  run, mode, age, now;
            bit  stable, shortv, longv, trig;
            now    = m_cyc + 1;
            stable = m_stable;
            run    = 0;
            if (m_s2 != m_stable) begin
                run = m_run + 1;
                if (run == DEB) begin
                    stable = m_s2;
                    run    = 0;
                end
            end
            mode = m_mode; age = m_age; shortv = 0; longv = 0;
            if (m_mode == 0) begin
                if (!m_stable) begin mode = 1; age = 0; end
            end else if (m_mode == 1) begin
                if (!m_stable) begin
                    if (m_age + 1 == LONG) begin longv = 1; mode = 2; end
                    else age = m_age + 1;
                end else begin
                    shortv = (m_age + 1 < LONG);
                    mode   = 0;
                end
            end else if (m_stable) begin
                mode = 0;
            end
            trig = m_por || longv || (magic_reboot && !m_reboot_prev);
            if (trig) m_last_trig <= now;
            m_req         <= (m_req || shortv || ps2_magic_key) && !magic_mode && exp_sys;
            m_s1          <= btn_n_raw;
            m_s2          <= m_s1;
            m_stable      <= stable;
            m_run         <= run;
            m_mode        <= mode;
            m_age         <= age;
            m_cyc         <= now;
            m_por         <= 1'b0;
            m_reboot_prev <= magic_reboot;
        end
    end

    always begin
        @(negedge clk28);
        #1;
        if (chk_en) begin
            check("magic_button_model", {31'd0, magic_button}, {31'd0, m_req});
            check("sys_rst_n_model", {31'd0, sys_rst_n}, {31'd0, exp_sys});
        end
    end

    // Runs n cycles; indices are clock edges counted from the call.
    task automatic watch(input int n, output int mb_first, output int low_first,
                         output int low_cnt, output int high_first);
        mb_first = 0; low_first = 0; low_cnt = 0; high_first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk28);
            #1;
            if (magic_button && mb_first == 0) mb_first = i;
            if (!sys_rst_n) begin
                low_cnt++;
                if (low_first == 0) low_first = i;
            end else if (high_first == 0) begin
                high_first = i;
            end
        end
    endtask

    int mb, lf, lc, hf;

    initial begin
        rst_n = 1'b0; btn_n_raw = 1'b1; ps2_magic_key = 1'b0;
        magic_mode = 1'b0; magic_reboot = 1'b0;
        repeat (3) @(negedge clk28);
        #1;
        check("reset_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        check("reset_magic_button", {31'd0, magic_button}, 32'd0);

        rst_n  = 1'b1;
        chk_en = 1'b1;
        watch(30, mb, lf, lc, hf);
        check("por_release_edge", hf, 17);
        check("por_no_request", mb, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_n_raw = ~btn_n_raw;
            watch(1, mb, lf, lc, hf);
        end
        btn_n_raw = 1'b1;
        watch(30, mb, lf, lc, hf);
        check("bounce_no_request", mb, 0);
        check("bounce_no_reset", lc, 0);

        btn_n_raw = 1'b0;
        watch(30, mb, lf, lc, hf);
        btn_n_raw = 1'b1;
        watch(20, mb, lf, lc, hf);
        check("short_press_latency", mb, 11);
        magic_mode = 1'b1;
        watch(1, mb, lf, lc, hf);
        check("ack_clears_request", {31'd0, magic_button}, 32'd0);
        watch(3, mb, lf, lc, hf);
        magic_mode = 1'b0;
        watch(5, mb, lf, lc, hf);
        check("ack_stays_clear", mb, 0);

        magic_mode = 1'b1;
        btn_n_raw = 1'b0;
        watch(30, mb, lf, lc, hf);
        btn_n_raw = 1'b1;
        watch(25, mb, lf, lc, hf);
        check("short_in_magic_mode", mb, 0);
        ps2_magic_key = 1'b1;
        watch(1, mb, lf, lc, hf);
        ps2_magic_key = 1'b0;
        watch(5, mb, lf, lc, hf);
        check("ps2_in_magic_mode", mb, 0);
        magic_mode = 1'b0;
        watch(2, mb, lf, lc, hf);

        ps2_magic_key = 1'b1;
        watch(1, mb, lf, lc, hf);
        ps2_magic_key = 1'b0;
        check("ps2_request_next_cycle", mb, 1);
        magic_mode = 1'b1;
        watch(2, mb, lf, lc, hf);
        magic_mode = 1'b0;
        watch(2, mb, lf, lc, hf);

        // Hotkey lands on the same cycle as the short_evt.
        btn_n_raw = 1'b0;
        watch(30, mb, lf, lc, hf);
        btn_n_raw = 1'b1;
        watch(10, mb, lf, lc, hf);
        ps2_magic_key = 1'b1;
        watch(1, mb, lf, lc, hf);
        ps2_magic_key = 1'b0;
        check("simultaneous_request", mb, 1);
        magic_mode = 1'b1;
        watch(2, mb, lf, lc, hf);
        magic_mode = 1'b0;
        watch(5, mb, lf, lc, hf);

        btn_n_raw = 1'b0;
        watch(200, mb, lf, lc, hf);
        check("long_press_reset_start", lf, 111);
        check("long_press_reset_len", lc, HOLD);
        btn_n_raw = 1'b1;
        watch(30, mb, lf, lc, hf);
        check("long_release_no_request", mb, 0);
        check("long_release_no_reset", lc, 0);

        btn_n_raw = 1'b0;
        watch(103, mb, lf, lc, hf);
        magic_reboot = 1'b1;
        watch(97, mb, lf, lc, hf);
        check("reboot_reset_start", lf, 1);
        check("reboot_retrigger_len", lc, 23);
        btn_n_raw = 1'b1;
        watch(60, mb, lf, lc, hf);
        check("reboot_held_no_pulse", lc, 0);
        magic_reboot = 1'b0;
        watch(5, mb, lf, lc, hf);

        btn_n_raw = 1'b0;
        watch(12, mb, lf, lc, hf);
        btn_n_raw = 1'b1;
        watch(2, mb, lf, lc, hf);
        magic_reboot = 1'b1;
        watch(40, mb, lf, lc, hf);
        check("short_lost_in_reset", mb, 0);
        check("reboot_only_len", lc, HOLD);
        magic_reboot = 1'b0;
        watch(5, mb, lf, lc, hf);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
